irq_priority_controller: RTL and testbench
==========================================

Name: irq_priority_controller

Overview:
- Parametrised N-channel interrupt controller between the peripheral interrupt lines and the core's single irq request / mret interface in processor_system.
- Captures per-channel requests (level or edge), applies a per-channel mask and a global enable, and selects the highest-priority pending channel.
- Presents one request to the core with a cause code, then returns a per-channel irq_ret pulse when the core executes mret.
- Successor to the single-line irq_req/irq_ret scheme: adds channel count, edge mode, priority arbitration and cause encoding.

Parameters:
- N_IRQ, 4, number of interrupt channels (1..16).
- EDGE_MASK, '0 (N_IRQ bits), bit k = 1 makes channel k rising-edge triggered; 0 makes it level triggered.
- CAUSE_BASE, 32'h8000_0010, mcause value for channel 0; channel k reports CAUSE_BASE + k.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- irq_req_i  in  N_IRQ  peripheral requests, synchronous to clk_i.
- mie_i  in  N_IRQ  per-channel enable (CSR mie); 1 = enabled.
- irq_en_i  in  1  global enable (mstatus.MIE).
- mret_i  in  1  one-cycle pulse from the core on mret.
- irq_o  out  1  interrupt request to the core.
- irq_cause_o  out  32  mcause of the channel being serviced.
- irq_ret_o  out  N_IRQ  one-hot, one-cycle completion pulse to the serviced peripheral.
- busy_o  out  1  high while a channel is in service.

Behaviour:
- Reset (rst_i = 0, asynchronous): state IDLE; pending, prev_req, active index, irq_o, irq_ret_o and busy_o all 0; irq_cause_o = 0.
- Pending capture, every cycle:
  - Level channel: pend[k] = irq_req_i[k], combinational and not stored.
  - Edge channel: pend[k] is set on irq_req_i[k] & ~prev_req[k]; prev_req is registered.
  - Edge channel: pend[k] is cleared only on that channel's own irq_ret.
  - If a new edge arrives in the same cycle as its clear, the set wins.
- Eligible vector: elig = pend & mie_i & {N_IRQ{irq_en_i}}.
- Priority: fixed; lowest index wins.
- FSM IDLE:
  - If elig != 0 at a rising edge, latch the winner index k, go to SERVICE, and register irq_o = 1, irq_cause_o = CAUSE_BASE + k, busy_o = 1.
  - Latency: request visible at the clock edge, irq_o high on the next cycle (1 cycle).
  - mret_i in IDLE is ignored; no irq_ret is generated.
- FSM SERVICE:
  - irq_o is a single-cycle pulse, high only in the first SERVICE cycle; the core traps on it.
  - irq_cause_o and busy_o are held constant.
  - No nesting: new or higher-priority requests stay pending.
  - Changes to the mask or global enable do not abort service.
  - On mret_i: register irq_ret_o[k] = 1 for one cycle, clear edge pending[k], go to IDLE; busy_o = 0 and irq_cause_o is held.
  - Re-arbitration happens in the first IDLE cycle, so the next irq_o comes no earlier than 2 cycles after mret_i.
  - A level channel still asserted after its irq_ret is re-serviced.
- Reset mid-SERVICE: immediately return to IDLE with everything cleared; no irq_ret is issued.
- Width rules:
  - irq_cause_o = CAUSE_BASE + zero-extended index, modulo 2^32.
  - The index register is $clog2(N_IRQ) bits wide, minimum 1.

Decomposition:
- Package irq_ctrl_pkg:
  - typedef enum logic {IDLE, SERVICE} irq_state_t.
  - localparam default CAUSE_BASE.
  - Function for cause encoding.
- Sub-module irq_prio_arbiter: purely combinational, parametrised N_IRQ.
  - Inputs: elig vector.
  - Outputs: valid and binary index of the lowest set bit.
- The top level holds the edge detection, pending register and FSM.

Test Plan (N_IRQ = 4, EDGE_MASK = 4'b0010):
- Reset: hold rst_i = 0 for 2 cycles with irq_req_i = 4'hF -> all outputs 0; deassert with mie_i = 0 -> irq_o stays 0.
- Single level request:
  - Stimulus: mie_i = 4'hF, irq_en_i = 1, irq_req_i[2] = 1.
  - Response: irq_o pulses 1 cycle later, irq_cause_o = 32'h8000_0012, busy_o = 1.
  - Then mret_i with irq_req_i[2] dropped: irq_ret_o = 4'b0100 for one cycle, busy_o = 0.
- Priority:
  - Stimulus: irq_req_i = 4'b1100 simultaneously.
  - Response: channel 2 is serviced first (cause 0x...12), then channel 3 (cause 0x...13) ≥2 cycles after mret_i.
  - Channel 0 asserted during channel 2's service does not preempt.
- Edge channel:
  - Stimulus: 1-cycle pulse on irq_req_i[1].
  - Response: stays pending, serviced with cause 0x...11.
  - A second pulse coinciding with mret_i leaves pending set, so it is re-serviced.
- Masking:
  - Stimulus: irq_en_i = 0 with requests present.
  - Response: no irq_o; setting irq_en_i = 1 produces irq_o on the next cycle.
  - mret_i in IDLE produces no irq_ret_o.
- Reset mid-SERVICE: assert rst_i = 0 while busy_o = 1 -> busy_o = 0 and irq_ret_o = 0 immediately, with no stray pulse after release.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the N-channel interrupt priority controller.
package irq_ctrl_pkg;

    typedef enum logic {IDLE, SERVICE} irq_state_t;

    localparam logic [31:0] DEFAULT_CAUSE_BASE = 32'h8000_0010;

    // mcause for a channel: base plus zero-extended index, wrapping modulo 2^32.
    function automatic logic [31:0] cause_encode(input logic [31:0] base,
                                                 input logic [31:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/irq_prio_arbiter.sv
// Fixed-priority arbiter: reports the index of the lowest set bit of elig.
module irq_prio_arbiter #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned IW    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] elig,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    always_comb begin
        valid = |elig;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last assignment.
        for (int unsigned i = N_IRQ; i > 0; i--) begin
            if (elig[i-1]) idx = IW'(i - 1);
        end
    end

endmodule

// File: rtl/irq_priority_controller.sv
// N-channel interrupt controller: level/edge capture, masking, fixed priority,
// single-request core handshake and per-channel completion pulse on mret.
module irq_priority_controller
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned      N_IRQ      = 4,
    parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
    parameter logic [31:0]      CAUSE_BASE = DEFAULT_CAUSE_BASE
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             irq_en_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ret_o,
    output logic             busy_o
);

    localparam int unsigned IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_t       state_q, state_d;
    logic [N_IRQ-1:0] prev_req_q;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             irq_d;
    logic [31:0]      cause_d;
    logic             busy_d;
    logic [N_IRQ-1:0] ret_d;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] edge_set;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] elig;
    logic             win_valid;
    logic [IW-1:0]    win_idx;

    // pend_q only ever holds edge-channel bits; level channels pass straight through.
    always_comb begin
        edge_set = irq_req_i & ~prev_req_q & EDGE_MASK;
        pend     = pend_q | (irq_req_i & ~EDGE_MASK);
        elig     = pend & mie_i & {N_IRQ{irq_en_i}};
    end

    irq_prio_arbiter #(
        .N_IRQ (N_IRQ),
        .IW    (IW)
    ) u_arb (
        .elig  (elig),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        irq_d   = 1'b0;
        cause_d = irq_cause_o;
        busy_d  = busy_o;
        ret_d   = '0;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = SERVICE;
                    idx_d   = win_idx;
                    irq_d   = 1'b1;
                    cause_d = cause_encode(CAUSE_BASE, 32'(win_idx));
                    busy_d  = 1'b1;
                end
            end
            SERVICE: begin
                if (mret_i) begin
                    ret_d   = N_IRQ'(1) << idx_q;
                    clr     = ret_d;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge in the same cycle as its own clear keeps the channel pending.
        pend_d = ((pend_q & ~clr) | edge_set) & EDGE_MASK;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            prev_req_q  <= '0;
            pend_q      <= '0;
            idx_q       <= '0;
            irq_o       <= 1'b0;
            irq_cause_o <= '0;
            irq_ret_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_req_q  <= irq_req_i;
            pend_q      <= pend_d;
            idx_q       <= idx_d;
            irq_o       <= irq_d;
            irq_cause_o <= cause_d;
            irq_ret_o   <= ret_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: tb/tb_irq_priority_controller.sv
// Directed self-checking bench for irq_priority_controller (N_IRQ=4, channel 1 edge-triggered).
module tb_irq_priority_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  irq_req_i;
    logic [3:0]  mie_i;
    logic        irq_en_i;
    logic        mret_i;
    logic        irq_o;
    logic [31:0] irq_cause_o;
    logic [3:0]  irq_ret_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    irq_priority_controller #(
        .N_IRQ      (4),
        .EDGE_MASK  (4'b0010),
        .CAUSE_BASE (32'h8000_0010)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .irq_req_i   (irq_req_i),
        .mie_i       (mie_i),
        .irq_en_i    (irq_en_i),
        .mret_i      (mret_i),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Compares all four outputs against expected values in one go.
    task automatic expect_out(input string name, input logic e_irq, input logic [31:0] e_cause,
                              input logic [3:0] e_ret, input logic e_busy);
        checks++;
        if (irq_o !== e_irq || irq_cause_o !== e_cause || irq_ret_o !== e_ret || busy_o !== e_busy) begin
            errors++;
            $display("FAIL %s: got irq=%b cause=%h ret=%b busy=%b, want irq=%b cause=%h ret=%b busy=%b",
                     name, irq_o, irq_cause_o, irq_ret_o, busy_o, e_irq, e_cause, e_ret, e_busy);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; irq_req_i = 4'hF; mie_i = 4'h0; irq_en_i = 1'b1; mret_i = 1'b0;
        tick(); tick();
        expect_out("reset_hold", 1'b0, 32'h0, 4'b0000, 1'b0);
        rst_i = 1'b1;
        tick(); tick();
        expect_out("reset_release_masked", 1'b0, 32'h0, 4'b0000, 1'b0);
        // Clear the edge pending captured above before the functional tests.
        irq_req_i = 4'h0; rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        expect_out("reset_clean", 1'b0, 32'h0, 4'b0000, 1'b0);
    endtask

    task automatic test_single_level();
        mie_i = 4'hF; irq_en_i = 1'b1; irq_req_i = 4'b0100;
        tick();
        expect_out("level_irq", 1'b1, 32'h8000_0012, 4'b0000, 1'b1);
        tick();
        expect_out("level_hold", 1'b0, 32'h8000_0012, 4'b0000, 1'b1);
        mret_i = 1'b1; irq_req_i = 4'b0000;
        tick();
        mret_i = 1'b0;
        expect_out("level_ret", 1'b0, 32'h8000_0012, 4'b0100, 1'b0);
        tick();
        expect_out("level_idle", 1'b0, 32'h8000_0012, 4'b0000, 1'b0);
    endtask

    task automatic test_priority();
        irq_req_i = 4'b1100;
        tick();
        expect_out("prio_first_ch2", 1'b1, 32'h8000_0012, 4'b0000, 1'b1);
        irq_req_i = 4'b1101;
        tick();
        expect_out("prio_no_preempt_a", 1'b0, 32'h8000_0012, 4'b0000, 1'b1);
        tick();
        expect_out("prio_no_preempt_b", 1'b0, 32'h8000_0012, 4'b0000, 1'b1);
        mret_i = 1'b1; irq_req_i = 4'b1000;
        tick();
        mret_i = 1'b0;
        expect_out("prio_ret_ch2", 1'b0, 32'h8000_0012, 4'b0100, 1'b0);
        tick();
        expect_out("prio_second_ch3", 1'b1, 32'h8000_0013, 4'b0000, 1'b1);
        mret_i = 1'b1; irq_req_i = 4'b0000;
        tick();
        mret_i = 1'b0;
        expect_out("prio_ret_ch3", 1'b0, 32'h8000_0013, 4'b1000, 1'b0);
        tick();
        expect_out("prio_idle", 1'b0, 32'h8000_0013, 4'b0000, 1'b0);
    endtask

    task automatic test_edge();
        irq_req_i = 4'b0010;
        tick();
        irq_req_i = 4'b0000;
        expect_out("edge_captured_no_irq_yet", 1'b0, 32'h8000_0013, 4'b0000, 1'b0);
        tick();
        expect_out("edge_irq", 1'b1, 32'h8000_0011, 4'b0000, 1'b1);
        tick();
        expect_out("edge_hold", 1'b0, 32'h8000_0011, 4'b0000, 1'b1);
        irq_req_i = 4'b0010; mret_i = 1'b1;
        tick();
        irq_req_i = 4'b0000; mret_i = 1'b0;
        expect_out("edge_ret_with_new_edge", 1'b0, 32'h8000_0011, 4'b0010, 1'b0);
        tick();
        expect_out("edge_reservice", 1'b1, 32'h8000_0011, 4'b0000, 1'b1);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        expect_out("edge_ret2", 1'b0, 32'h8000_0011, 4'b0010, 1'b0);
        tick(); tick();
        expect_out("edge_cleared", 1'b0, 32'h8000_0011, 4'b0000, 1'b0);
    endtask

    task automatic test_masking();
        irq_en_i = 1'b0; irq_req_i = 4'b0100;
        tick(); tick();
        expect_out("mask_global_off", 1'b0, 32'h8000_0011, 4'b0000, 1'b0);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        expect_out("mask_mret_idle", 1'b0, 32'h8000_0011, 4'b0000, 1'b0);
        irq_en_i = 1'b1;
        tick();
        expect_out("mask_enable_irq", 1'b1, 32'h8000_0012, 4'b0000, 1'b1);
        irq_en_i = 1'b0; mie_i = 4'h0;
        tick();
        expect_out("mask_no_abort", 1'b0, 32'h8000_0012, 4'b0000, 1'b1);
    endtask

    task automatic test_reset_mid_service();
        mret_i = 1'b1;
        rst_i = 1'b0;
        #1;
        expect_out("rst_mid_service_async", 1'b0, 32'h0, 4'b0000, 1'b0);
        tick();
        expect_out("rst_mid_service_hold", 1'b0, 32'h0, 4'b0000, 1'b0);
        mret_i = 1'b0; irq_req_i = 4'b0000; mie_i = 4'hF; irq_en_i = 1'b1;
        rst_i = 1'b1;
        tick(); tick();
        expect_out("rst_release_no_stray", 1'b0, 32'h0, 4'b0000, 1'b0);
    endtask

    initial begin
        rst_i = 1'b0; irq_req_i = '0; mie_i = '0; irq_en_i = 1'b0; mret_i = 1'b0;
        test_reset();
        test_single_level();
        test_priority();
        test_edge();
        test_masking();
        test_reset_mid_service();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
